// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the MIPS control/datapath and mult_div_unit.
interface mult_div_unit_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output mult_start, div_start, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  mult_start, div_start, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) unit producing HI/LO.
// Divider datapath is compiled in only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_cnt;
    // Booth accumulator {hi(33), lo(32), q-1}; the extra hi bit absorbs add/sub overflow
    logic signed [65:0] r_acc;
    logic signed [32:0] r_mcand;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_dz;
    logic               w_last;
    logic               w_start_mult;
    logic               w_start_div;
    logic signed [32:0] w_sum;
    logic signed [65:0] w_acc_nxt;

    assign w_last       = (r_cnt == 5'd31);
    assign w_start_mult = bus.mult_start;
    assign w_start_div  = bus.div_start & ~bus.mult_start;

    always_comb begin
        w_sum = r_acc[65:33];
        case (r_acc[1:0])
            2'b01:   w_sum = r_acc[65:33] + r_mcand;
            2'b10:   w_sum = r_acc[65:33] - r_mcand;
            default: w_sum = r_acc[65:33];
        endcase
        w_acc_nxt = {w_sum[32], w_sum, r_acc[32:1]};
    end

`ifdef MULT_DIV_UNIT_DIV_EN
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_qneg;
    logic        r_rneg;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        w_rem_sh  = {r_rem[31:0], r_quo[31]};
        w_quo_nxt = {r_quo[30:0], 1'b0};
        w_rem_nxt = w_rem_sh;
        if (w_rem_sh >= {1'b0, r_dvs}) begin
            w_rem_nxt    = w_rem_sh - {1'b0, r_dvs};
            w_quo_nxt[0] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_mult)     w_next = S_MULT;
                else if (w_start_div) w_next = S_DIV;
            end
            S_MULT: if (w_last) w_next = S_DONE;
`ifdef MULT_DIV_UNIT_DIV_EN
            S_DIV:  if (r_dz || w_last) w_next = S_DONE;
`else
            S_DIV:  w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (r_state == S_MULT) || (r_state == S_DIV);
        bus.done     = (r_state == S_DONE);
        bus.div_zero = (r_state == S_DONE) && r_dz;
    end

    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
                    r_dz  <= w_start_div && (bus.b_in == 32'd0);
`else
                    r_dz  <= 1'b0;
`endif
                    if (w_start_mult) begin
                        r_acc   <= {33'd0, bus.b_in, 1'b0};
                        r_mcand <= {bus.a_in[31], bus.a_in};
                    end
`ifdef MULT_DIV_UNIT_DIV_EN
                    else if (w_start_div) begin
                        r_rem  <= '0;
                        r_quo  <= mag32(bus.a_in);
                        r_dvs  <= mag32(bus.b_in);
                        r_qneg <= bus.a_in[31] ^ bus.b_in[31];
                        r_rneg <= bus.a_in[31];
                    end
`endif
                end
                S_MULT: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_hi <= w_acc_nxt[64:33];
                        r_lo <= w_acc_nxt[32:1];
                    end
                end
`ifdef MULT_DIV_UNIT_DIV_EN
                S_DIV: begin
                    if (!r_dz) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 5'd1;
                        // remainder is below the divisor magnitude, so 32 bits suffice
                        if (w_last) begin
                            r_hi <= apply_sign(w_rem_nxt[31:0], r_rneg);
                            r_lo <= apply_sign(w_quo_nxt, r_qneg);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
